// File: rtl/core_scheduler_if.sv
// Core phase encoding and the handshake bundle between the scheduler and
// the fetcher, decoder, LSUs and lane logic.
package core_scheduler_pkg;
    typedef enum logic [2:0] {
        CORE_IDLE    = 3'd0,
        CORE_FETCH   = 3'd1,
        CORE_DECODE  = 3'd2,
        CORE_REQUEST = 3'd3,
        CORE_WAIT    = 3'd4,
        CORE_EXECUTE = 3'd5,
        CORE_UPDATE  = 3'd6,
        CORE_DONE    = 3'd7
    } corestate_t;
endpackage

interface core_scheduler_if #(
    parameter int THREADS_PER_BLOCK     = 4,
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int COUNT_BITS            = 16
);
    import core_scheduler_pkg::*;

    logic                                            start;
    logic [THREADS_PER_BLOCK-1:0]                    thread_enable;
    logic                                            fetch_done;
    logic                                            decoded_mem_read_enable;
    logic                                            decoded_mem_write_enable;
    logic                                            decoded_ret;
    logic [THREADS_PER_BLOCK-1:0]                    lsu_busy;
    logic [THREADS_PER_BLOCK*PROGRAM_MEM_ADDR_BITS-1:0] next_pc;
    corestate_t                                      core_state;
    logic [PROGRAM_MEM_ADDR_BITS-1:0]                current_pc;
    logic                                            done;
    logic [COUNT_BITS-1:0]                           retired_count;

    // master is the scheduler; slave is the surrounding core datapath
    modport master (
        input  start, thread_enable, fetch_done, decoded_mem_read_enable,
               decoded_mem_write_enable, decoded_ret, lsu_busy, next_pc,
        output core_state, current_pc, done, retired_count
    );

    modport slave (
        output start, thread_enable, fetch_done, decoded_mem_read_enable,
               decoded_mem_write_enable, decoded_ret, lsu_busy, next_pc,
        input  core_state, current_pc, done, retired_count
    );
endinterface

// File: rtl/core_scheduler.sv
// Per-core pipeline sequencer: walks the phases, owns the shared PC and
// counts retired instructions.
//
// state        | meaning
// CORE_IDLE    | waiting for start
// CORE_FETCH   | waiting for fetcher to present the instruction at current_pc
// CORE_DECODE  | decoder registers its outputs
// CORE_REQUEST | LSUs sample their request
// CORE_WAIT    | waiting for all enabled lanes' LSUs to go idle
// CORE_EXECUTE | ALUs compute
// CORE_UPDATE  | register writeback, PC advance or block end
// CORE_DONE    | block finished, only reset leaves
module core_scheduler #(
    parameter int THREADS_PER_BLOCK     = 4,
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int COUNT_BITS            = 16
) (
    input logic            clk,
    input logic            reset,
    core_scheduler_if.master bus
);
    import core_scheduler_pkg::*;

    localparam int B = PROGRAM_MEM_ADDR_BITS;

    logic [B-1:0] chosen_pc;
    logic         lanes_busy;

    // Lowest-index enabled lane wins; no enabled lane falls through sequentially.
    always_comb begin
        chosen_pc = bus.current_pc + B'(1);
        for (int i = THREADS_PER_BLOCK - 1; i >= 0; i--) begin
            if (bus.thread_enable[i]) begin
                chosen_pc = bus.next_pc[i*B +: B];
            end
        end
    end

    assign lanes_busy = |(bus.lsu_busy & bus.thread_enable);

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.core_state    <= CORE_IDLE;
            bus.current_pc    <= '0;
            bus.done          <= 1'b0;
            bus.retired_count <= '0;
        end else begin
            case (bus.core_state)
                CORE_IDLE: begin
                    if (bus.start) begin
                        bus.core_state    <= CORE_FETCH;
                        bus.current_pc    <= '0;
                        bus.retired_count <= '0;
                    end
                end
                CORE_FETCH: begin
                    if (bus.fetch_done) begin
                        bus.core_state <= CORE_DECODE;
                    end
                end
                CORE_DECODE:  bus.core_state <= CORE_REQUEST;
                CORE_REQUEST: bus.core_state <= CORE_WAIT;
                CORE_WAIT: begin
                    if (!lanes_busy) begin
                        bus.core_state <= CORE_EXECUTE;
                    end
                end
                CORE_EXECUTE: bus.core_state <= CORE_UPDATE;
                CORE_UPDATE: begin
                    if (bus.retired_count != '1) begin
                        bus.retired_count <= bus.retired_count + COUNT_BITS'(1);
                    end
                    if (bus.decoded_ret) begin
                        bus.core_state <= CORE_DONE;
                        bus.done       <= 1'b1;
                    end else begin
                        bus.current_pc <= chosen_pc;
                        bus.core_state <= CORE_FETCH;
                    end
                end
                CORE_DONE: bus.core_state <= CORE_DONE;
                default:   bus.core_state <= CORE_IDLE;
            endcase
        end
    end

    // An LSU can only be busy on an instruction that actually touches memory.
    a_lsu_busy_without_mem_op: assert property (
        @(posedge clk) disable iff (reset)
        !(bus.core_state == CORE_WAIT && lanes_busy &&
          !bus.decoded_mem_read_enable && !bus.decoded_mem_write_enable)
    );

endmodule

// File: tb/tb_core_scheduler.sv
// Randomized, self-checking bench for core_scheduler against a per-instruction
// phase model.
module tb_core_scheduler;
    import core_scheduler_pkg::*;

    localparam int T  = 4;
    localparam int B  = 8;
    localparam int CB = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    core_scheduler_if #(.THREADS_PER_BLOCK(T), .PROGRAM_MEM_ADDR_BITS(B), .COUNT_BITS(CB)) bus ();

    core_scheduler #(.THREADS_PER_BLOCK(T), .PROGRAM_MEM_ADDR_BITS(B), .COUNT_BITS(CB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [B-1:0]  m_pc;
    logic [CB-1:0] m_cnt;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [B-1:0] ref_next_pc(input logic [T-1:0] te,
                                                  input logic [T*B-1:0] np,
                                                  input logic [B-1:0] pc);
        logic [T-1:0] low;
        int lane;
        if (te == '0) return pc + B'(1);
        low  = te & (~te + T'(1));
        lane = $countones(low - T'(1));
        return np[lane*B +: B];
    endfunction

    function automatic logic [CB-1:0] ref_count(input logic [CB-1:0] c);
        return (c == {CB{1'b1}}) ? c : c + CB'(1);
    endfunction

    // Runs one instruction starting with the DUT observed in FETCH.
    task automatic run_instr(input string name, input logic [T-1:0] te, input int fd_delay,
                             input int busy_hold, input logic [T-1:0] busy,
                             input logic [T*B-1:0] np, input logic ret, input logic use_wr);
        corestate_t exp_q[$];
        corestate_t final_st;
        int wait_len;
        int fi = 0;
        int wi = 0;
        logic [B-1:0] exp_pc;
        wait_len = (((busy & te) != '0) && busy_hold > 0) ? busy_hold + 1 : 1;
        for (int k = 0; k <= fd_delay; k++) exp_q.push_back(CORE_FETCH);
        exp_q.push_back(CORE_DECODE);
        exp_q.push_back(CORE_REQUEST);
        for (int k = 0; k < wait_len; k++) exp_q.push_back(CORE_WAIT);
        exp_q.push_back(CORE_EXECUTE);
        exp_q.push_back(CORE_UPDATE);

        bus.thread_enable            = te;
        bus.next_pc                  = np;
        bus.decoded_ret              = ret;
        bus.decoded_mem_read_enable  = (busy != '0) && !use_wr;
        bus.decoded_mem_write_enable = (busy != '0) && use_wr;
        foreach (exp_q[k]) begin
            if (bus.core_state !== exp_q[k]) begin
                errors++;
                $display("FAIL %s state cycle %0d: got %0d expected %0d", name, k, bus.core_state, exp_q[k]);
            end
            checks++;
            bus.fetch_done = 1'b0;
            bus.lsu_busy   = '0;
            if (exp_q[k] == CORE_FETCH) begin
                bus.fetch_done = (fi == fd_delay);
                fi++;
            end
            if (exp_q[k] == CORE_WAIT) begin
                bus.lsu_busy = (wi < busy_hold) ? busy : '0;
                wi++;
            end
            tick();
        end
        bus.fetch_done = 1'b0;
        bus.lsu_busy   = '0;

        exp_pc   = ret ? m_pc : ref_next_pc(te, np, m_pc);
        m_pc     = exp_pc;
        m_cnt    = ref_count(m_cnt);
        final_st = ret ? CORE_DONE : CORE_FETCH;
        if (bus.core_state !== final_st) begin
            errors++;
            $display("FAIL %s end state: got %0d expected %0d", name, bus.core_state, final_st);
        end
        checks++;
        if (bus.current_pc !== m_pc) begin
            errors++;
            $display("FAIL %s pc: got %0h expected %0h", name, bus.current_pc, m_pc);
        end
        checks++;
        if (bus.retired_count !== m_cnt) begin
            errors++;
            $display("FAIL %s retired_count: got %0d expected %0d", name, bus.retired_count, m_cnt);
        end
        checks++;
        if (bus.done !== ret) begin
            errors++;
            $display("FAIL %s done: got %0b expected %0b", name, bus.done, ret);
        end
        checks++;
    endtask

    task automatic do_start(input string name);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        m_pc  = '0;
        m_cnt = '0;
        if (bus.core_state !== CORE_FETCH || bus.current_pc !== 8'h00 || bus.retired_count !== '0) begin
            errors++;
            $display("FAIL %s start: got state %0d pc %0h cnt %0d expected state %0d pc 0 cnt 0",
                     name, bus.core_state, bus.current_pc, bus.retired_count, CORE_FETCH);
        end
        checks++;
    endtask

    function automatic logic [T*B-1:0] all_lanes(input logic [B-1:0] v);
        return {T{v}};
    endfunction

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        if (bus.core_state !== CORE_IDLE) begin
            errors++;
            $display("FAIL reset state: got %0d expected %0d", bus.core_state, CORE_IDLE);
        end
        checks++;
        if (bus.current_pc !== 8'h00 || bus.done !== 1'b0 || bus.retired_count !== '0) begin
            errors++;
            $display("FAIL reset outputs: got pc %0h done %0b cnt %0d expected 0 0 0",
                     bus.current_pc, bus.done, bus.retired_count);
        end
        checks++;
        reset = 1'b0;
        tick();
        if (bus.core_state !== CORE_IDLE) begin
            errors++;
            $display("FAIL idle hold: got %0d expected %0d", bus.core_state, CORE_IDLE);
        end
        checks++;
    endtask

    task automatic test_sequential;
        do_start("sequential");
        for (int i = 0; i < 3; i++)
            run_instr("sequential", 4'b1111, 0, 0, '0, all_lanes(m_pc + B'(1)), 1'b0, 1'b0);
        if (bus.current_pc !== 8'd3 || bus.retired_count !== CB'(3)) begin
            errors++;
            $display("FAIL sequential after 18: got pc %0d cnt %0d expected 3 3", bus.current_pc, bus.retired_count);
        end
        checks++;
    endtask

    task automatic test_fetch_stall;
        run_instr("fetch_stall", 4'b1111, 5, 0, '0, all_lanes(m_pc + B'(1)), 1'b0, 1'b0);
    endtask

    task automatic test_lsu_wait;
        run_instr("lsu_wait_enabled", 4'b1111, 0, 6, 4'b0100, all_lanes(m_pc + B'(1)), 1'b0, 1'b0);
        run_instr("lsu_wait_masked", 4'b1011, 0, 6, 4'b0100, all_lanes(m_pc + B'(1)), 1'b0, 1'b0);
    endtask

    task automatic test_branch;
        run_instr("branch", 4'b1100, 0, 0, '0, {8'h40, 8'h30, 8'h20, 8'h10}, 1'b0, 1'b0);
    endtask

    task automatic test_no_lanes_wrap;
        run_instr("to_ff", 4'b1111, 0, 0, '0, all_lanes(8'hFF), 1'b0, 1'b0);
        run_instr("no_lanes_wrap", 4'b0000, 0, 0, '0, all_lanes(8'h55), 1'b0, 1'b0);
    endtask

    task automatic test_random;
        for (int i = 0; i < 30; i++) begin
            logic [T*B-1:0] np;
            for (int l = 0; l < T; l++) np[l*B +: B] = B'($urandom_range(0, 255));
            run_instr("random", T'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 4),
                      T'($urandom_range(0, 15)), np, 1'b0, 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_ret;
        logic [CB-1:0] cnt_done;
        run_instr("to_05", 4'b0001, 0, 0, '0, {8'h99, 8'h88, 8'h77, 8'h05}, 1'b0, 1'b0);
        run_instr("ret", 4'b1111, 1, 0, '0, all_lanes(8'h66), 1'b1, 1'b0);
        cnt_done = m_cnt;
        bus.decoded_ret = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        if (bus.core_state !== CORE_DONE || bus.done !== 1'b1 || bus.current_pc !== 8'h05 ||
            bus.retired_count !== cnt_done) begin
            errors++;
            $display("FAIL done absorbing: got state %0d done %0b pc %0h cnt %0d expected %0d 1 05 %0d",
                     bus.core_state, bus.done, bus.current_pc, bus.retired_count, CORE_DONE, cnt_done);
        end
        checks++;
    endtask

    task automatic test_reset_mid_wait;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        if (bus.core_state !== CORE_IDLE || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset from done: got state %0d done %0b expected %0d 0", bus.core_state, bus.done, CORE_IDLE);
        end
        checks++;
        do_start("mid_wait");
        run_instr("mid_wait_pre", 4'b1111, 0, 0, '0, all_lanes(8'h77), 1'b0, 1'b0);
        bus.fetch_done = 1'b1;
        tick();
        tick();
        bus.fetch_done               = 1'b0;
        bus.lsu_busy                 = 4'b1111;
        bus.decoded_mem_read_enable  = 1'b1;
        bus.decoded_mem_write_enable = 1'b0;
        tick();
        tick();
        if (bus.core_state !== CORE_WAIT) begin
            errors++;
            $display("FAIL mid_wait reach: got %0d expected %0d", bus.core_state, CORE_WAIT);
        end
        checks++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        if (bus.core_state !== CORE_IDLE || bus.current_pc !== 8'h00 || bus.done !== 1'b0 ||
            bus.retired_count !== '0) begin
            errors++;
            $display("FAIL mid_wait reset: got state %0d pc %0h done %0b cnt %0d expected %0d 0 0 0",
                     bus.core_state, bus.current_pc, bus.done, bus.retired_count, CORE_IDLE);
        end
        checks++;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.lsu_busy = '0;
        if (bus.core_state !== CORE_FETCH) begin
            errors++;
            $display("FAIL mid_wait restart: got %0d expected %0d", bus.core_state, CORE_FETCH);
        end
        checks++;
    endtask

    initial begin
        reset                        = 1'b1;
        bus.start                    = 1'b0;
        bus.thread_enable            = '0;
        bus.fetch_done               = 1'b0;
        bus.decoded_mem_read_enable  = 1'b0;
        bus.decoded_mem_write_enable = 1'b0;
        bus.decoded_ret              = 1'b0;
        bus.lsu_busy                 = '0;
        bus.next_pc                  = '0;
        m_pc                         = '0;
        m_cnt                        = '0;
        test_reset();
        test_sequential();
        test_fetch_stall();
        test_lsu_wait();
        test_branch();
        test_no_lanes_wrap();
        test_random();
        test_ret();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
